fix_length_packets2bytes: RTL and testbench
===========================================

# fix_length_packets2bytes

Avalon-ST packet-to-byte converter: accepts fixed-length packets of 17-bit complex symbols {real[7:0], imag[7:0], flag}, checks framing and length, strips packet boundaries and emits a plain byte stream. It sits after the packet-processing chain and returns packetized sample data to a byte-oriented consumer (UART/FIFO/DMA). Framing errors are reported on single-cycle status pulses and never stall the stream.

## Interface
- PACKET_LEN, 1024: required symbols per packet (SOP..EOP inclusive), 1..8191
- EMIT_IMAG, 0: 0 = one byte (real) per symbol; 1 = two bytes per symbol, real then imag
- clock_clk  in  1  single clock, all logic on rising edge
- reset_reset_n  in  1  synchronous, active-low reset
- asi_in0_data  in  17  [16:9] real, [8:1] imag, [0] flag (1 = forward symbol)
- asi_in0_valid  in  1  sink beat valid
- asi_in0_ready  out  1  sink ready (readyLatency 0)
- asi_in0_startofpacket  in  1  first beat of packet
- asi_in0_endofpacket  in  1  last beat of packet
- asi_in0_empty  in  1  ignored
- aso_out0_data  out  8  output byte
- aso_out0_valid  out  1  byte valid
- aso_out0_ready  in  1  downstream ready (readyLatency 0)
- pkt_done  out  1  one-cycle pulse when a packet EOP is accepted
- err_len  out  1  one-cycle pulse: packet length != PACKET_LEN
- err_orphan  out  1  one-cycle pulse: beat accepted outside a packet
- pkt_ok_count  out  16  count of correct-length packets, wraps at 65535 -> 0

## Operation
- Beat accepted when asi_in0_valid && asi_in0_ready.
- State IDLE: accepted beat without SOP -> discarded, err_orphan pulse. Beat with SOP -> symbol count = 1, go IN_PKT (stay IDLE if EOP on same beat).
- State IN_PKT: each accepted beat increments 13-bit count (saturates at 8191). Beat with SOP -> err_len pulse, count restarts at 1, stay IN_PKT (new packet begins).
- EOP beat (either state, after SOP): pkt_done pulse; if final count == PACKET_LEN, pkt_ok_count increments, else err_len pulse; go IDLE, count = 0.
- Forwarding: a symbol inside a packet is forwarded iff flag == 1 and its index (1-based) <= PACKET_LEN; overlong beats are consumed and dropped. Discarded/dropped beats never occupy the output buffer.
- Output buffer: one symbol register plus byte-select bit. EMIT_IMAG=0: emits real. EMIT_IMAG=1: emits real, then imag; byte-select toggles on each output handshake.
- asi_in0_ready = reset_reset_n && (buffer empty || (aso_out0_ready && last byte of buffered symbol presented)). Ready is independent of asi_in0_valid.

## Timing
- Reset (reset_reset_n low at clock edge): state IDLE, count 0, buffer empty, byte-select 0; aso_out0_valid 0, aso_out0_data 0x00, pkt_done 0, err_len 0, err_orphan 0, pkt_ok_count 0; asi_in0_ready 0 while reset low. Reset mid-packet abandons the packet and the buffered symbol with no pulses.
- Latency: symbol accepted at edge N -> aso_out0_valid high from edge N through to its handshake, data = real byte. Imag byte (EMIT_IMAG=1) follows on the cycle after the real-byte handshake.
- Throughput: EMIT_IMAG=0 one symbol/cycle with aso_out0_ready held high (simultaneous output handshake and input accept); EMIT_IMAG=1 one symbol per two cycles.
- aso_out0_data/valid stable while valid && !ready.
- Status pulses (pkt_done, err_len, err_orphan) registered, high exactly the cycle after the causing beat edge; pkt_ok_count updates same edge. pkt_done and err_len may assert together.
- SOP+EOP on one beat: length 1, checked against PACKET_LEN.

## Test plan
- PACKET_LEN=4, EMIT_IMAG=0, ready=1: packet reals 0x11,0x22,0x33,0x44 flag=1 -> bytes 0x11,0x22,0x33,0x44 on consecutive cycles, pkt_done once, pkt_ok_count=1, no errors.
- EMIT_IMAG=1: symbols (0xA1,0xB1),(0xA2,0xB2) -> bytes A1,B1,A2,B2; asi_in0_ready low every second cycle.
- Backpressure: aso_out0_ready toggling 1,0,0,1 during packet -> no byte lost or duplicated, data stable while stalled, asi_in0_ready low while buffer full.
- Framing: 2 beats without SOP then 3-beat packet with PACKET_LEN=4 -> 2 err_orphan pulses, discarded bytes absent, 3 bytes out, err_len + pkt_done, pkt_ok_count unchanged.
- Overlong 6-beat packet (PACKET_LEN=4) -> only first 4 bytes out, err_len at EOP; SOP mid-packet -> err_len, new packet counted from 1; flag=0 symbols counted, not emitted.
- Reset low mid-packet with byte stalled -> next cycle valid 0, counters 0; following clean packet handled normally.

Source files
------------

// File: rtl/fix_length_packets2bytes.sv
// Purpose : strips fixed-length packets of {real,imag,flag} symbols down to a plain byte stream,
//           checking framing/length and reporting errors on one-cycle status pulses.
// Latency : symbol accepted at edge N is presented (real byte) from edge N; imag byte follows its handshake.
// Backpres: one-symbol output buffer; sink ready drops while the buffered symbol's last byte is not leaving.
// Ports   : clock_clk/reset_reset_n (sync, active-low); asi_in0_* Avalon-ST sink (17-bit symbols);
//           aso_out0_* Avalon-ST byte source; pkt_done/err_len/err_orphan pulses; pkt_ok_count.
module fix_length_packets2bytes #(
  parameter int PACKET_LEN = 1024,
  parameter int EMIT_IMAG  = 0
) (
  input  logic        clock_clk,
  input  logic        reset_reset_n,
  input  logic [16:0] asi_in0_data,
  input  logic        asi_in0_valid,
  output logic        asi_in0_ready,
  input  logic        asi_in0_startofpacket,
  input  logic        asi_in0_endofpacket,
  input  logic        asi_in0_empty,
  output logic [7:0]  aso_out0_data,
  output logic        aso_out0_valid,
  input  logic        aso_out0_ready,
  output logic        pkt_done,
  output logic        err_len,
  output logic        err_orphan,
  output logic [15:0] pkt_ok_count
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  localparam logic [12:0] PLEN      = 13'(PACKET_LEN);
  localparam logic [12:0] CNT_MAX   = '1;
  localparam bit          TWO_BYTES = (EMIT_IMAG != 0);

  state_t      state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic        buf_vld_q, buf_vld_d;
  logic [15:0] sym_q, sym_d;
  logic        sel_q, sel_d;
  logic        pkt_done_q, pkt_done_d;
  logic        err_len_q, err_len_d;
  logic        err_orphan_q, err_orphan_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;

  logic        last_byte;
  logic        beat_acc;
  logic        out_hs;
  logic        fwd;
  logic [12:0] idx;
  logic        unused_empty;

  assign unused_empty = asi_in0_empty;

  // The byte on the output is the final one of its symbol when only reals are
  // emitted, or when the imag half is being presented.
  assign last_byte     = !TWO_BYTES || sel_q;
  assign asi_in0_ready = reset_reset_n && (!buf_vld_q || (aso_out0_ready && last_byte));
  assign beat_acc      = asi_in0_valid && asi_in0_ready;
  assign out_hs        = buf_vld_q && aso_out0_ready;

  assign aso_out0_valid = buf_vld_q;
  assign aso_out0_data  = sel_q ? sym_q[7:0] : sym_q[15:8];
  assign pkt_done       = pkt_done_q;
  assign err_len        = err_len_q;
  assign err_orphan     = err_orphan_q;
  assign pkt_ok_count   = ok_cnt_q;

  // Framing / length tracking.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pkt_done_d   = 1'b0;
    err_len_d    = 1'b0;
    err_orphan_d = 1'b0;
    ok_cnt_d     = ok_cnt_q;
    idx          = '0;
    fwd          = 1'b0;
    if (beat_acc) begin
      if (state_q == IDLE && !asi_in0_startofpacket) begin
        err_orphan_d = 1'b1;
      end else begin
        if (asi_in0_startofpacket) begin
          // SOP while a packet is open abandons it as a length error.
          if (state_q == IN_PKT) err_len_d = 1'b1;
          idx = 13'd1;
        end else begin
          idx = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 13'd1;
        end
        fwd = asi_in0_data[0] && (idx <= PLEN);
        if (asi_in0_endofpacket) begin
          pkt_done_d = 1'b1;
          if (idx == PLEN) ok_cnt_d = ok_cnt_q + 16'd1;
          else             err_len_d = 1'b1;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = IN_PKT;
          cnt_d   = idx;
        end
      end
    end
  end

  // Output buffer: a new symbol can only land when the buffer is empty or its
  // last byte leaves this cycle, so loading takes priority over draining.
  always_comb begin
    buf_vld_d = buf_vld_q;
    sym_d     = sym_q;
    sel_d     = sel_q;
    if (fwd) begin
      buf_vld_d = 1'b1;
      sym_d     = asi_in0_data[16:1];
      sel_d     = 1'b0;
    end else if (out_hs) begin
      if (last_byte) begin
        buf_vld_d = 1'b0;
        sel_d     = 1'b0;
      end else begin
        sel_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock_clk) begin
    if (!reset_reset_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      buf_vld_q    <= 1'b0;
      sym_q        <= '0;
      sel_q        <= 1'b0;
      pkt_done_q   <= 1'b0;
      err_len_q    <= 1'b0;
      err_orphan_q <= 1'b0;
      ok_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      buf_vld_q    <= buf_vld_d;
      sym_q        <= sym_d;
      sel_q        <= sel_d;
      pkt_done_q   <= pkt_done_d;
      err_len_q    <= err_len_d;
      err_orphan_q <= err_orphan_d;
      ok_cnt_q     <= ok_cnt_d;
    end
  end

endmodule

// File: tb/tb_fix_length_packets2bytes.sv
module tb_fix_length_packets2bytes;

  localparam int PLEN   = 4;
  localparam int BUDGET = 3000;

  typedef struct packed {
    logic [7:0] re;
    logic [7:0] im;
    logic       flag;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct packed {
    logic [7:0] dat;
    logic       last;
  } obyte_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        sel;      // 0: real-only instance, 1: real+imag instance
  logic [16:0] in_dat;
  logic        in_vld, in_sop, in_eop, in_emp, out_rdy;

  logic        rdy0, rdy1, ov0, ov1, pd0, pd1, el0, el1, eo0, eo1;
  logic [7:0]  od0, od1;
  logic [15:0] cnt0, cnt1;

  logic        in_rdy, ov, pd, el, eo;
  logic [7:0]  od;
  logic [15:0] okc;

  assign in_rdy = sel ? rdy1 : rdy0;
  assign ov     = sel ? ov1  : ov0;
  assign od     = sel ? od1  : od0;
  assign pd     = sel ? pd1  : pd0;
  assign el     = sel ? el1  : el0;
  assign eo     = sel ? eo1  : eo0;
  assign okc    = sel ? cnt1 : cnt0;

  fix_length_packets2bytes #(.PACKET_LEN(PLEN), .EMIT_IMAG(0)) dut0 (
    .clock_clk(clk), .reset_reset_n(rst_n),
    .asi_in0_data(in_dat), .asi_in0_valid(in_vld && !sel), .asi_in0_ready(rdy0),
    .asi_in0_startofpacket(in_sop), .asi_in0_endofpacket(in_eop), .asi_in0_empty(in_emp),
    .aso_out0_data(od0), .aso_out0_valid(ov0), .aso_out0_ready(out_rdy),
    .pkt_done(pd0), .err_len(el0), .err_orphan(eo0), .pkt_ok_count(cnt0));

  fix_length_packets2bytes #(.PACKET_LEN(PLEN), .EMIT_IMAG(1)) dut1 (
    .clock_clk(clk), .reset_reset_n(rst_n),
    .asi_in0_data(in_dat), .asi_in0_valid(in_vld && sel), .asi_in0_ready(rdy1),
    .asi_in0_startofpacket(in_sop), .asi_in0_endofpacket(in_eop), .asi_in0_empty(in_emp),
    .aso_out0_data(od1), .aso_out0_valid(ov1), .aso_out0_ready(out_rdy),
    .pkt_done(pd1), .err_len(el1), .err_orphan(eo1), .pkt_ok_count(cnt1));

  int n_checks = 0;
  int n_pass   = 0;
  int exp_ok[2];

  beat_t  beats[$];
  bit     m_orph[$], m_done[$], m_len[$], m_ok[$];
  obyte_t exp_q[$];

  function automatic void add_beat(input logic [7:0] re, input logic [7:0] im,
                                   input logic flag, input logic sop, input logic eop);
    beat_t b;
    b.re = re; b.im = im; b.flag = flag; b.sop = sop; b.eop = eop;
    beats.push_back(b);
  endfunction

  // Reference: walk the beat list as packets, with an unbounded length count.
  function automatic void build_model(input bit two);
    bit in_pkt, o, d, l, k, f;
    int len;
    obyte_t ob;
    in_pkt = 0; len = 0;
    m_orph.delete(); m_done.delete(); m_len.delete(); m_ok.delete(); exp_q.delete();
    foreach (beats[i]) begin
      o = 0; d = 0; l = 0; k = 0; f = 0;
      if (!in_pkt && !beats[i].sop) begin
        o = 1;
      end else begin
        if (beats[i].sop) begin
          l = in_pkt;
          len = 1;
        end else begin
          len++;
        end
        f = beats[i].flag && (len <= PLEN);
        if (beats[i].eop) begin
          d = 1;
          if (len == PLEN) k = 1; else l = 1;
          in_pkt = 0;
        end else begin
          in_pkt = 1;
        end
      end
      m_orph.push_back(o); m_done.push_back(d); m_len.push_back(l); m_ok.push_back(k);
      if (f) begin
        ob.dat = beats[i].re; ob.last = !two; exp_q.push_back(ob);
        if (two) begin
          ob.dat = beats[i].im; ob.last = 1'b1; exp_q.push_back(ob);
        end
      end
    end
  endfunction

  // Drives the beat list with random valid gaps and output ready (rdy_pct < 0
  // selects the repeating 1,0,0,1 ready pattern) and scores every cycle.
  task automatic run_stream(input int vld_pct, input int rdy_pct,
                            output int hs_first, output int hs_last, output int hs_n);
    int bi, cyc;
    bit pend, stall, e_o, e_d, e_l, e_k;
    logic [7:0] stall_dat;
    logic [3:0] pat;
    obyte_t head;
    pat = 4'b1001;
    bi = 0; cyc = 0; pend = 0; stall = 0; stall_dat = '0;
    e_o = 0; e_d = 0; e_l = 0; e_k = 0;
    hs_first = -1; hs_last = -1; hs_n = 0;
    build_model(sel);
    forever begin
      @(negedge clk);
      in_vld = 1'b0;
      if (pend && e_k) exp_ok[sel] = (exp_ok[sel] + 1) % 65536;
      n_checks++;
      if ({pd, el, eo} !== (pend ? {e_d, e_l, e_o} : 3'b000))
        $display("FAIL pulses cyc=%0d beat=%0d: got done/len/orphan=%b%b%b want %b", cyc, bi, pd, el, eo,
                 pend ? {e_d, e_l, e_o} : 3'b000);
      else n_pass++;
      n_checks++;
      if (okc !== 16'(exp_ok[sel])) $display("FAIL pkt_ok_count cyc=%0d: got %0d want %0d", cyc, okc, exp_ok[sel]);
      else n_pass++;
      pend = 0;
      if (stall) begin
        n_checks++;
        if (ov !== 1'b1 || od !== stall_dat)
          $display("FAIL stall_hold cyc=%0d: got valid=%b data=%h want valid=1 data=%h", cyc, ov, od, stall_dat);
        else n_pass++;
      end
      if (bi == beats.size() && exp_q.size() == 0 && ov === 1'b0) break;
      if (cyc >= BUDGET) begin
        n_checks++;
        $display("FAIL stream_timeout: beats accepted %0d of %0d, bytes outstanding %0d", bi, beats.size(), exp_q.size());
        break;
      end
      cyc++;
      out_rdy = (rdy_pct < 0) ? pat[cyc % 4] : ($urandom_range(99) < rdy_pct);
      in_emp  = 1'($urandom);
      if (bi < beats.size() && $urandom_range(99) < vld_pct) begin
        in_vld = 1'b1;
        in_dat = {beats[bi].re, beats[bi].im, beats[bi].flag};
        in_sop = beats[bi].sop;
        in_eop = beats[bi].eop;
      end else begin
        in_vld = 1'b0;
        in_dat = 17'($urandom);
        in_sop = 1'($urandom);
        in_eop = 1'($urandom);
      end
      #1;
      if (ov === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL extra_byte cyc=%0d: got data=%h want no valid byte", cyc, od);
        end else begin
          head = exp_q[0];
          if (in_rdy !== (out_rdy && head.last))
            $display("FAIL in_ready_full cyc=%0d: got %b want %b", cyc, in_rdy, out_rdy && head.last);
          else n_pass++;
          if (out_rdy) begin
            void'(exp_q.pop_front());
            n_checks++;
            if (od !== head.dat) $display("FAIL byte cyc=%0d: got %h want %h", cyc, od, head.dat);
            else n_pass++;
            if (hs_first < 0) hs_first = cyc;
            hs_last = cyc;
            hs_n++;
          end
        end
      end else begin
        n_checks++;
        if (in_rdy !== 1'b1) $display("FAIL in_ready_empty cyc=%0d: got %b want 1", cyc, in_rdy);
        else n_pass++;
      end
      stall = (ov === 1'b1) && !out_rdy;
      stall_dat = od;
      if (in_vld && in_rdy) begin
        pend = 1;
        e_o = m_orph[bi]; e_d = m_done[bi]; e_l = m_len[bi]; e_k = m_ok[bi];
        bi++;
      end
    end
    in_vld = 1'b0;
    out_rdy = 1'b1;
    beats.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    sel = 0; in_vld = 0; in_dat = '0; in_sop = 0; in_eop = 0; in_emp = 0; out_rdy = 0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({ov0, ov1, od0, od1} !== 18'h0) $display("FAIL reset_out: got valid=%b%b data=%h/%h want 0", ov0, ov1, od0, od1);
    else n_pass++;
    n_checks++;
    if ({pd0, el0, eo0, pd1, el1, eo1} !== 6'b0) $display("FAIL reset_pulses: got %b want 000000", {pd0, el0, eo0, pd1, el1, eo1});
    else n_pass++;
    n_checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0) $display("FAIL reset_count: got %0d/%0d want 0", cnt0, cnt1);
    else n_pass++;
    n_checks++;
    if ({rdy0, rdy1} !== 2'b00) $display("FAIL reset_ready: got %b want 00", {rdy0, rdy1});
    else n_pass++;
    rst_n = 1;
    out_rdy = 1;
    exp_ok[0] = 0; exp_ok[1] = 0;
  endtask

  task automatic test_basic();
    int f, l, n;
    sel = 0;
    add_beat(8'h11, 8'h01, 1, 1, 0);
    add_beat(8'h22, 8'h02, 1, 0, 0);
    add_beat(8'h33, 8'h03, 1, 0, 0);
    add_beat(8'h44, 8'h04, 1, 0, 1);
    run_stream(100, 100, f, l, n);
    n_checks++;
    if (n != 4 || l - f != 3) $display("FAIL basic_throughput: got %0d bytes over %0d cycles want 4 over 4", n, l - f + 1);
    else n_pass++;
  endtask

  task automatic test_imag();
    int f, l, n;
    sel = 1;
    add_beat(8'hA1, 8'hB1, 1, 1, 0);
    add_beat(8'hA2, 8'hB2, 1, 0, 0);
    add_beat(8'hA3, 8'hB3, 1, 0, 0);
    add_beat(8'hA4, 8'hB4, 1, 0, 1);
    run_stream(100, 100, f, l, n);
    n_checks++;
    if (n != 8 || l - f != 7) $display("FAIL imag_throughput: got %0d bytes over %0d cycles want 8 over 8", n, l - f + 1);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int f, l, n;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 4; i++) add_beat(8'(8'h50 + i), 8'(8'h60 + i), 1, i == 0, i == 3);
      run_stream(100, -1, f, l, n);
      n_checks++;
      if (n != 4 * (s + 1)) $display("FAIL backpressure_count sel=%0d: got %0d want %0d", s, n, 4 * (s + 1));
      else n_pass++;
    end
  endtask

  task automatic test_framing();
    int f, l, n;
    sel = 0;
    add_beat(8'hE1, 8'h00, 1, 0, 0);
    add_beat(8'hE2, 8'h00, 1, 0, 1);
    add_beat(8'h71, 8'h00, 1, 1, 0);
    add_beat(8'h72, 8'h00, 1, 0, 0);
    add_beat(8'h73, 8'h00, 1, 0, 1);
    add_beat(8'h80, 8'h00, 1, 1, 1);  // single-beat packet, length 1
    run_stream(100, 100, f, l, n);
    n_checks++;
    if (n != 4) $display("FAIL framing_bytes: got %0d want 4", n);
    else n_pass++;
  endtask

  task automatic test_overlong();
    int f, l, n;
    sel = 0;
    for (int i = 0; i < 6; i++) add_beat(8'(8'h90 + i), 8'h00, 1, i == 0, i == 5);
    add_beat(8'hC0, 8'h00, 1, 1, 0);
    add_beat(8'hC1, 8'h00, 1, 0, 0);
    for (int i = 0; i < 4; i++) add_beat(8'(8'hD0 + i), 8'h00, 1, i == 0, i == 3);
    for (int i = 0; i < 4; i++) add_beat(8'(8'hF0 + i), 8'h00, i[0] == 1'b0, i == 0, i == 3);
    run_stream(70, 70, f, l, n);
    n_checks++;
    if (n != 4 + 2 + 4 + 2) $display("FAIL overlong_bytes: got %0d want 12", n);
    else n_pass++;
  endtask

  task automatic test_random();
    int f, l, n;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      for (int i = 0; i < 200; i++)
        add_beat(8'($urandom), 8'($urandom), $urandom_range(99) < 80,
                 $urandom_range(99) < 25, (i == 199) || ($urandom_range(99) < 25));
      run_stream(75, 60, f, l, n);
    end
  endtask

  task automatic test_reset_mid();
    int f, l, n;
    sel = 0;
    @(negedge clk);
    out_rdy = 0;
    in_vld = 1; in_dat = {8'h5A, 8'h00, 1'b1}; in_sop = 1; in_eop = 0;
    @(negedge clk);
    in_dat = {8'h6B, 8'h00, 1'b1}; in_sop = 0;
    #1;
    n_checks++;
    if (ov0 !== 1'b1 || od0 !== 8'h5A || rdy0 !== 1'b0)
      $display("FAIL pre_reset_stall: got valid=%b data=%h ready=%b want 1/5a/0", ov0, od0, rdy0);
    else n_pass++;
    rst_n = 0;
    @(negedge clk);
    in_vld = 0;
    n_checks++;
    if (ov0 !== 1'b0 || od0 !== 8'h00 || rdy0 !== 1'b0)
      $display("FAIL mid_reset_out: got valid=%b data=%h ready=%b want 0/00/0", ov0, od0, rdy0);
    else n_pass++;
    n_checks++;
    if (cnt0 !== 16'd0 || cnt1 !== 16'd0 || {pd0, el0, eo0} !== 3'b0)
      $display("FAIL mid_reset_state: got counts %0d/%0d pulses %b want 0/0/000", cnt0, cnt1, {pd0, el0, eo0});
    else n_pass++;
    rst_n = 1;
    out_rdy = 1;
    exp_ok[0] = 0; exp_ok[1] = 0;
    for (int i = 0; i < 4; i++) add_beat(8'(8'h31 + i), 8'h00, 1, i == 0, i == 3);
    run_stream(100, 100, f, l, n);
    n_checks++;
    if (n != 4) $display("FAIL post_reset_bytes: got %0d want 4", n);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_imag();
    test_backpressure();
    test_framing();
    test_overlong();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
